// File: rtl/rst_sync_seq.sv
// Reset synchroniser and sequencer: synchronises an external reset request,
// qualifies it with a hold time, then releases NUM_CH resets in order.
//
// Ports:
//   CLK        block clock, rising edge
//   RST        synchronous active-high block reset
//   RST_REQ_N  asynchronous active-low external reset request
//   SW_RST     synchronous active-high software reset request (level)
//   SYNC_RST   active-low per-channel resets, bit 0 released first
//   RST_DONE   high once every channel is released
//   RST_STATE  FSM state for debug (0 ASSERT, 1 STABLE, 2 RELEASE, 3 DONE)
module rst_sync_seq #(
    parameter int NUM_STAGES  = 2,
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8,
    parameter int CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RST_REQ_N,
    input  logic              SW_RST,
    output logic [NUM_CH-1:0] SYNC_RST,
    output logic              RST_DONE,
    output logic [1:0]        RST_STATE
);

    localparam int IDX_W = $clog2(NUM_CH) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STABLE  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                state;
    logic [NUM_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  req_sync;
    logic                  assert_req;

    assign req_sync   = sync_q[NUM_STAGES-1];
    assign assert_req = ~req_sync | SW_RST;
    assign RST_STATE  = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q   <= '0;
            state    <= ST_ASSERT;
            cnt      <= '0;
            idx      <= '0;
            SYNC_RST <= '0;
            RST_DONE <= 1'b0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], RST_REQ_N};

            // Assertion is never sequenced: every channel drops together.
            if (assert_req) begin
                state    <= ST_ASSERT;
                cnt      <= '0;
                idx      <= '0;
                SYNC_RST <= '0;
                RST_DONE <= 1'b0;
            end else begin
                case (state)
                    ST_ASSERT: begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                    ST_STABLE: begin
                        if (cnt == HOLD_LAST) begin
                            SYNC_RST <= NUM_CH'(1);
                            cnt      <= '0;
                            idx      <= IDX_W'(1);
                            if (NUM_CH == 1) begin
                                state    <= ST_DONE;
                                RST_DONE <= 1'b1;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (cnt == GAP_LAST) begin
                            // Shifting a one in keeps the output thermometer-coded.
                            SYNC_RST <= (SYNC_RST << 1) | NUM_CH'(1);
                            cnt      <= '0;
                            if (idx == IDX_LAST) begin
                                state    <= ST_DONE;
                                RST_DONE <= 1'b1;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: begin
                        state <= ST_ASSERT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: directed vector table, a hand-written
// single-channel sequence and randomized stimulus against a reference model.
module tb_rst_sync_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RST_REQ_N;
    logic       SW_RST;
    logic [3:0] sync_a;
    logic       done_a;
    logic [1:0] st_a;
    logic [0:0] sync_b;
    logic       done_b;
    logic [1:0] st_b;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    rst_sync_seq dut_a (
        .CLK       (CLK),
        .RST       (RST),
        .RST_REQ_N (RST_REQ_N),
        .SW_RST    (SW_RST),
        .SYNC_RST  (sync_a),
        .RST_DONE  (done_a),
        .RST_STATE (st_a)
    );

    rst_sync_seq #(
        .NUM_STAGES  (3),
        .NUM_CH      (1),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (8),
        .CNT_W       (8)
    ) dut_b (
        .CLK       (CLK),
        .RST       (RST),
        .RST_REQ_N (RST_REQ_N),
        .SW_RST    (SW_RST),
        .SYNC_RST  (sync_b),
        .RST_DONE  (done_b),
        .RST_STATE (st_b)
    );

    // Reference model: counts consecutive edges on which no assertion
    // request was seen; released channels follow from that count.
    int         p_ns[2]   = '{2, 3};
    int         p_ch[2]   = '{4, 1};
    int         p_hold[2] = '{16, 1};
    int         p_gap[2]  = '{8, 8};
    logic [3:0] sh[2];
    int         q[2];

    function automatic int n_rel(int m);
        int r;
        if (q[m] <= p_hold[m]) return 0;
        r = 1 + (q[m] - p_hold[m] - 1) / p_gap[m];
        return (r > p_ch[m]) ? p_ch[m] : r;
    endfunction

    task automatic model_step();
        logic ar;
        for (int m = 0; m < 2; m++) begin
            if (RST) begin
                sh[m] = '0;
                q[m]  = 0;
            end else begin
                ar = !sh[m][p_ns[m]-1] || SW_RST;
                if (ar) q[m] = 0;
                else if (q[m] < 100000) q[m] = q[m] + 1;
                sh[m] = {sh[m][2:0], RST_REQ_N};
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        int es;
        int ed;
        int est;
        for (int m = 0; m < 2; m++) begin
            n   = n_rel(m);
            es  = (1 << n) - 1;
            ed  = (n == p_ch[m]) ? 1 : 0;
            est = (q[m] == 0) ? 0 : (n == p_ch[m]) ? 3 : (n > 0) ? 2 : 1;
            if (m == 0) begin
                chk("model_a sync", int'(sync_a), es);
                chk("model_a done", int'(done_a), ed);
                chk("model_a state", int'(st_a), est);
            end else begin
                chk("model_b sync", int'(sync_b), es);
                chk("model_b done", int'(done_b), ed);
                chk("model_b state", int'(st_b), est);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            model_step();
            #1;
            check_model();
        end
    endtask

    typedef struct {
        logic       rst;
        logic       req_n;
        logic       sw;
        int         cyc;
        logic [3:0] sync;
        logic       done;
        logic [1:0] st;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic rq, input logic s,
                       input int c, input logic [3:0] y,
                       input logic d, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.req_n = rq; v.sw = s; v.cyc = c;
        v.sync = y; v.done = d; v.st = st;
        tv.push_back(v);
    endtask

    initial begin
        int mode;
        int len;

        RST       = 1'b1;
        RST_REQ_N = 1'b0;
        SW_RST    = 1'b0;
        sh[0] = '0; sh[1] = '0;
        q[0]  = 0;  q[1]  = 0;

        // reset
        add(1, 0, 0, 3,  4'b0000, 0, 0);
        // full release after first sampling edge e0
        add(0, 1, 0, 18, 4'b0000, 0, 1);
        add(0, 1, 0, 1,  4'b0001, 0, 2);
        add(0, 1, 0, 8,  4'b0011, 0, 2);
        add(0, 1, 0, 7,  4'b0011, 0, 2);
        add(0, 1, 0, 1,  4'b0111, 0, 2);
        add(0, 1, 0, 8,  4'b1111, 1, 3);
        add(0, 1, 0, 5,  4'b1111, 1, 3);
        // one-cycle request pulse in DONE, then re-release
        add(0, 0, 0, 1,  4'b1111, 1, 3);
        add(0, 1, 0, 1,  4'b1111, 1, 3);
        add(0, 1, 0, 1,  4'b0000, 0, 0);
        add(0, 1, 0, 1,  4'b0000, 0, 1);
        add(0, 1, 0, 15, 4'b0000, 0, 1);
        add(0, 1, 0, 1,  4'b0001, 0, 2);
        add(0, 1, 0, 8,  4'b0011, 0, 2);
        // software abort during release
        add(0, 1, 1, 1,  4'b0000, 0, 0);
        add(0, 1, 0, 16, 4'b0000, 0, 1);
        add(0, 1, 0, 1,  4'b0001, 0, 2);
        add(0, 1, 0, 24, 4'b1111, 1, 3);
        // SW_RST held keeps everything asserted
        add(0, 1, 1, 30, 4'b0000, 0, 0);
        add(0, 1, 0, 1,  4'b0000, 0, 1);
        // short deassertion never releases
        add(0, 0, 0, 4,  4'b0000, 0, 0);
        add(0, 1, 0, 10, 4'b0000, 0, 1);
        add(0, 0, 0, 4,  4'b0000, 0, 0);
        // block reset during release restarts the whole chain
        add(0, 1, 0, 20, 4'b0001, 0, 2);
        add(1, 1, 0, 1,  4'b0000, 0, 0);
        add(0, 1, 0, 18, 4'b0000, 0, 1);
        add(0, 1, 0, 1,  4'b0001, 0, 2);

        foreach (tv[i]) begin
            RST       = tv[i].rst;
            RST_REQ_N = tv[i].req_n;
            SW_RST    = tv[i].sw;
            tick(tv[i].cyc);
            chk($sformatf("vec%0d sync", i), int'(sync_a), int'(tv[i].sync));
            chk($sformatf("vec%0d done", i), int'(done_a), int'(tv[i].done));
            chk($sformatf("vec%0d state", i), int'(st_a), int'(tv[i].st));
        end

        // single channel, hold 1, three stages
        RST       = 1'b1;
        RST_REQ_N = 1'b1;
        SW_RST    = 1'b0;
        tick(2);
        chk("b reset sync", int'(sync_b), 0);
        chk("b reset done", int'(done_b), 0);
        RST = 1'b0;
        tick(4);
        chk("b e3 sync", int'(sync_b), 0);
        chk("b e3 done", int'(done_b), 0);
        chk("b e3 state", int'(st_b), 1);
        tick(1);
        chk("b e4 sync", int'(sync_b), 1);
        chk("b e4 done", int'(done_b), 1);
        chk("b e4 state", int'(st_b), 3);

        // randomized traffic, checked every cycle by the model
        repeat (70) begin
            mode = $urandom_range(0, 9);
            case (mode)
                0: begin
                    RST = 1'b1;
                    tick($urandom_range(1, 3));
                    RST = 1'b0;
                end
                1: begin
                    SW_RST = 1'b1;
                    tick($urandom_range(1, 4));
                    SW_RST = 1'b0;
                end
                2, 3: begin
                    RST_REQ_N = 1'b0;
                    len = $urandom_range(1, 20);
                    tick(len);
                    RST_REQ_N = 1'b1;
                end
                default: begin
                    RST_REQ_N = 1'b1;
                    tick($urandom_range(1, 80));
                end
            endcase
        end
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
